// File: rtl/factorial_ctrl_if.sv
// Start/result handshake bundle for the factorial engine.
// The master drives go/n, and the slave (engine) returns ready/done/result/overflow.
interface factorial_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic [7:0]       n;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;

  modport master (
    output go,
    output n,
    input  ready,
    input  done,
    input  result,
    input  overflow
  );

  modport slave (
    input  go,
    input  n,
    output ready,
    output done,
    output result,
    output overflow
  );
endinterface

// File: rtl/factorial_ctrl.sv
// Iterative n! engine: an FSM sequences a 9-bit counter, a product register and a multiplier.
// Optional macro FACT_SAT_EN saturates the product to all-ones once it overflows.
module factorial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  factorial_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       n_q, n_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_out_q, ovf_out_d;

  logic [WIDTH+8:0] mul_s;
  logic             hi_nz_s;
  logic [WIDTH-1:0] prod_next_s;
  logic             exit_s;

  assign mul_s   = {9'd0, prod_q} * {{WIDTH{1'b0}}, cnt_q};
  assign hi_nz_s = |mul_s[WIDTH+8:WIDTH];
  assign exit_s  = ({1'b0, n_q} < cnt_q);

`ifdef FACT_SAT_EN
  assign prod_next_s = (ovf_q | hi_nz_s) ? {WIDTH{1'b1}} : mul_s[WIDTH-1:0];
`else
  assign prod_next_s = mul_s[WIDTH-1:0];
`endif

  // State and datapath registers; reset dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= 8'd0;
      cnt_q     <= 9'd0;
      prod_q    <= {WIDTH{1'b0}};
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {WIDTH{1'b0}};
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      result_q  <= result_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  // Next-state and datapath control; done/result are registered while leaving DONE.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    result_d  = result_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          n_d     = bus.n;
          cnt_d   = 9'd2;
          prod_d  = {{(WIDTH-1){1'b0}}, 1'b1};
          ovf_d   = 1'b0;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (exit_s) begin
          state_d = DONE;
        end else begin
          prod_d  = prod_next_s;
          cnt_d   = cnt_q + 9'd1;
          ovf_d   = ovf_q | hi_nz_s;
          state_d = CHECK;
        end
      end
      DONE: begin
        done_d    = 1'b1;
        result_d  = prod_q;
        ovf_out_d = ovf_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_out_q;

endmodule

// File: tb/tb_factorial_ctrl.sv
// Self-checking bench for factorial_ctrl: directed scenarios plus randomized operands
// checked against an arithmetic reference model (honours FACT_SAT_EN).
module tb_factorial_ctrl;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] last_res;
  logic        last_ov;

  factorial_ctrl_if #(.WIDTH(WIDTH)) bus ();

  factorial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Exact factorial while it fits, plus the residue mod 2^32.
  task automatic model(input int n, output logic [31:0] res, output logic ov);
    longint unsigned exact;
    longint unsigned m;
    exact = 64'd1;
    m     = 64'd1;
    ov    = 1'b0;
    for (int i = 2; i <= n; i++) begin
      m = (m * longint'(i)) % 64'h1_0000_0000;
      if (!ov) begin
        exact = exact * longint'(i);
        if (exact >= 64'h1_0000_0000) ov = 1'b1;
      end
    end
    res = m[31:0];
`ifdef FACT_SAT_EN
    if (ov) res = 32'hFFFF_FFFF;
`endif
  endtask

  function automatic int exp_lat(input int n);
    return ((n > 1) ? (n - 1) : 0) + 2;
  endfunction

  // Leaves the bench at the negedge of the first cycle after the accept edge.
  task automatic start(input int n);
    @(negedge clk);
    check_eq("ready_before_go", {63'd0, bus.ready}, 64'd1);
    bus.go = 1'b1;
    bus.n  = n[7:0];
    @(posedge clk);
    @(negedge clk);
    bus.go = 1'b0;
    check_eq("ready_after_accept", {63'd0, bus.ready}, 64'd0);
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.done && lat < 400);
  endtask

  task automatic check_result(input string tag, input int n, input int lat);
    logic [31:0] r;
    logic        o;
    model(n, r, o);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat(n)));
    check_eq({tag, "_result"}, {32'd0, bus.result}, {32'd0, r});
    check_eq({tag, "_overflow"}, {63'd0, bus.overflow}, {63'd0, o});
    last_res = r;
    last_ov  = o;
  endtask

  task automatic run(input string tag, input int n);
    int lat;
    start(n);
    check_eq({tag, "_result_held"}, {32'd0, bus.result}, {32'd0, last_res});
    wait_done(0, lat);
    check_result(tag, n, lat);
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    int lat;
    int rn;
    rst    = 1'b1;
    bus.go = 1'b0;
    bus.n  = 8'd0;
    last_res = 32'd0;
    last_ov  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ready", {63'd0, bus.ready}, 64'd1);
    check_eq("rst_done", {63'd0, bus.done}, 64'd0);
    check_eq("rst_result", {32'd0, bus.result}, 64'd0);
    check_eq("rst_overflow", {63'd0, bus.overflow}, 64'd0);

    run("n5", 5);
    run("n0", 0);
    run("n1", 1);
    run("n12", 12);
    run("n13", 13);

    // go during CHECK is ignored, then go held high re-accepts right after done.
    start(4);
    @(posedge clk);
    @(negedge clk);
    bus.go = 1'b1;
    bus.n  = 8'd9;
    @(posedge clk);
    @(negedge clk);
    bus.go = 1'b0;
    wait_done(2, lat);
    check_result("n4_ignore", 4, lat);
    bus.go = 1'b1;
    bus.n  = 8'd6;
    @(posedge clk);
    @(negedge clk);
    bus.go = 1'b0;
    check_eq("b2b_ready", {63'd0, bus.ready}, 64'd0);
    check_eq("b2b_done_low", {63'd0, bus.done}, 64'd0);
    wait_done(0, lat);
    check_result("n6_b2b", 6, lat);

    // Reset in the middle of a computation.
    start(10);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_ready", {63'd0, bus.ready}, 64'd1);
    check_eq("midrst_done", {63'd0, bus.done}, 64'd0);
    check_eq("midrst_result", {32'd0, bus.result}, 64'd0);
    check_eq("midrst_overflow", {63'd0, bus.overflow}, 64'd0);
    last_res = 32'd0;
    run("n3", 3);

    run("n255", 255);

    for (int i = 0; i < 20; i++) begin
      rn = int'($urandom_range(0, 20));
      run("rand_small", rn);
    end
    for (int i = 0; i < 4; i++) begin
      rn = int'($urandom_range(0, 255));
      run("rand_full", rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
